// File: rtl/i2c_master_core.sv
// Single-byte I2C master: one write or one read to a 7-bit addressed slave per command.
// Each bit slot is two clk cycles: phase 0 with SCL low (drive changes), phase 1 with SCL high (sample).
module i2c_master_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       read,
  input  logic       data_send_master_enable,
  input  logic [7:0] data_send_master,
  input  logic [6:0] slave_address,
  inout  wire        sda,
  output logic       scl,
  output logic [7:0] data_receive_master,
  output logic       data_receive_master_enable,
  output logic       error_master
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_START     = 4'd1;
  localparam logic [3:0] ST_ADDR      = 4'd2;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd3;
  localparam logic [3:0] ST_WDATA     = 4'd4;
  localparam logic [3:0] ST_WDATA_ACK = 4'd5;
  localparam logic [3:0] ST_RDATA     = 4'd6;
  localparam logic [3:0] ST_RNACK     = 4'd7;
  localparam logic [3:0] ST_STOP      = 4'd8;

  logic [3:0] state_q, state_d;
  logic       phase_q, phase_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic [7:0] rx_q, rx_d;
  logic       strobe_q, strobe_d;
  logic       error_q, error_d;
  logic       sda_low;
  logic       sda_in;

  assign sda_in = sda;
  assign sda    = sda_low ? 1'b0 : 1'bz;

  assign data_receive_master        = rx_q;
  assign data_receive_master_enable = strobe_q;
  assign error_master               = error_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = (state_q == ST_IDLE) ? 1'b0 : ~phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    rx_d      = rx_q;
    strobe_d  = 1'b0;
    error_d   = error_q;
    case (state_q)
      ST_IDLE: begin
        // Write has priority when both commands arrive together.
        if (data_send_master_enable) begin
          shift_d = {slave_address, 1'b0};
          wdata_d = data_send_master;
          rw_d    = 1'b0;
          error_d = 1'b0;
          state_d = ST_START;
        end else if (read) begin
          shift_d = {slave_address, 1'b1};
          rw_d    = 1'b1;
          error_d = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (phase_q) begin
          bit_cnt_d = 3'd7;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR, ST_WDATA: begin
        if (phase_q) begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0)
            state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WDATA_ACK;
        end
      end
      ST_ADDR_ACK: begin
        if (phase_q) begin
          bit_cnt_d = 3'd7;
          if (sda_in == 1'b0) begin
            shift_d = wdata_q;
            state_d = rw_q ? ST_RDATA : ST_WDATA;
          end else begin
            error_d = 1'b1;
            state_d = ST_STOP;
          end
        end
      end
      ST_WDATA_ACK: begin
        if (phase_q) begin
          if (sda_in != 1'b0)
            error_d = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_RDATA: begin
        if (phase_q) begin
          shift_d   = {shift_q[6:0], sda_in};
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            rx_d     = {shift_q[6:0], sda_in};
            strobe_d = 1'b1;
            state_d  = ST_RNACK;
          end
        end
      end
      ST_RNACK: begin
        if (phase_q)
          state_d = ST_STOP;
      end
      ST_STOP: begin
        if (phase_q)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus pins are decoded from state so a reset shows idle levels in the very next cycle.
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    case (state_q)
      ST_IDLE:  scl = 1'b1;
      ST_START: sda_low = 1'b1;
      ST_ADDR, ST_WDATA: begin
        scl     = phase_q;
        sda_low = ~shift_q[7];
      end
      ST_STOP: begin
        scl     = phase_q;
        sda_low = 1'b1;
      end
      default: scl = phase_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      wdata_q   <= 8'h00;
      rw_q      <= 1'b0;
      rx_q      <= 8'h00;
      strobe_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      rx_q      <= rx_d;
      strobe_q  <= strobe_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_core.sv
// Scoreboard bench for i2c_master_core: a bus monitor decodes each transfer and a slave model answers it.
module tb_i2c_master_core;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       ack_addr;
    logic       ack_data;
    int         c0;
  } txn_t;

  typedef struct {
    logic [7:0] data;
    int         c0;
  } rd_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       read;
  logic       data_send_master_enable;
  logic [7:0] data_send_master;
  logic [6:0] slave_address;
  wire        sda;
  logic       scl;
  logic [7:0] data_receive_master;
  logic       data_receive_master_enable;
  logic       error_master;
  logic       slave_low = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  txn_t exp_q[$];
  rd_t  rd_q[$];
  logic [7:0] last_rx = 8'h00;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_master_core dut (
    .clk                        (clk),
    .rst                        (rst),
    .read                       (read),
    .data_send_master_enable    (data_send_master_enable),
    .data_send_master           (data_send_master),
    .slave_address              (slave_address),
    .sda                        (sda),
    .scl                        (scl),
    .data_receive_master        (data_receive_master),
    .data_receive_master_enable (data_receive_master_enable),
    .error_master               (error_master)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Slave drive for slot n of the current transfer (1 = pull SDA low).
  function automatic logic slave_drive(input int n, input logic [31:0] seen);
    txn_t t;
    if (exp_q.size() == 0) return 1'b0;
    t = exp_q[0];
    if (n == 8) return t.ack_addr;
    if (n >= 9 && n <= 16 && seen[7]) return ~t.data[16 - n];
    if (n == 17) return !seen[7] && t.ack_data;
    return 1'b0;
  endfunction

  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        in_txn = 1'b0;
  int          nbits = 0;
  logic [31:0] bits = '0;

  task automatic finish_txn();
    txn_t t;
    logic [7:0] b;
    checkOutput("txn_expected", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    t = exp_q.pop_front();
    checkOutput("slot_count", nbits, t.ack_addr ? 19 : 10);
    for (int i = 0; i < 8; i++) b[7 - i] = bits[i];
    checkOutput("addr_rw_byte", b, {t.addr, t.rw});
    if (t.ack_addr) begin
      for (int i = 0; i < 8; i++) b[7 - i] = bits[9 + i];
      checkOutput("data_byte", b, t.data);
      if (t.rw) checkOutput("master_nack", bits[17], 1);
    end
    if (nbits > 0) checkOutput("stop_slot_low", bits[nbits - 1], 0);
    checkOutput("stop_cycle", cyc, t.ack_addr ? t.c0 + 40 : t.c0 + 22);
    checkOutput("error_at_stop", error_master, !t.ack_addr || (!t.rw && !t.ack_data));
    checkOutput("rx_hold", data_receive_master, last_rx);
  endtask

  // Bus monitor and slave model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      in_txn    = 1'b0;
      slave_low = 1'b0;
    end else begin
      if (!in_txn && prev_scl && scl && prev_sda && !sda) begin
        in_txn = 1'b1;
        nbits  = 0;
        bits   = '0;
      end else if (in_txn && prev_scl && scl && !prev_sda && sda) begin
        in_txn = 1'b0;
        finish_txn();
      end else if (in_txn && !prev_scl && scl && nbits < 32) begin
        bits[nbits] = sda;
        nbits++;
      end
      if (in_txn && !scl) slave_low = slave_drive(nbits, bits);
      else if (!in_txn) slave_low = 1'b0;
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  logic prev_strobe = 1'b0;
  logic prev_err = 1'b0;

  // Read-strobe and error-rise monitor.
  always @(negedge clk) begin
    if (!rst && data_receive_master_enable) begin
      checkOutput("strobe_one_cycle", prev_strobe, 0);
      checkOutput("strobe_expected", rd_q.size() != 0, 1);
      if (rd_q.size() != 0) begin
        rd_t r;
        r = rd_q.pop_front();
        checkOutput("rx_data", data_receive_master, r.data);
        checkOutput("strobe_cycle", cyc, r.c0 + 36);
        last_rx = r.data;
      end
    end
    if (!rst && error_master && !prev_err) begin
      checkOutput("error_rise_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        checkOutput("error_rise_cycle", cyc, exp_q[0].ack_addr ? exp_q[0].c0 + 38 : exp_q[0].c0 + 20);
    end
    prev_strobe = data_receive_master_enable;
    prev_err    = error_master;
  end

  task automatic applyStimulus(input logic [6:0] a, input logic [7:0] d, input logic wr, input logic rd,
                               input logic ack_a, input logic ack_d, input logic busy_poke);
    txn_t t;
    rd_t  r;
    @(negedge clk);
    slave_address           = a;
    data_send_master        = d;
    data_send_master_enable = wr;
    read                    = rd;
    @(posedge clk);
    #1;
    t.addr = a; t.rw = !wr; t.data = d; t.ack_addr = ack_a; t.ack_data = ack_d; t.c0 = cyc;
    exp_q.push_back(t);
    if (!wr && ack_a) begin
      r.data = d;
      r.c0   = cyc;
      rd_q.push_back(r);
    end
    checkOutput("error_clear_on_accept", error_master, 0);
    data_send_master_enable = 1'b0;
    read                    = 1'b0;
    data_send_master        = ~d;
    slave_address           = ~a;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (busy_poke && i >= 8 && i < 14) begin
        read                    = 1'b1;
        data_send_master_enable = 1'b1;
        slave_address           = 7'h01;
        data_send_master        = 8'hE7;
      end else begin
        read                    = 1'b0;
        data_send_master_enable = 1'b0;
      end
    end
    checkOutput("txn_complete", exp_q.size() == 0, 1);
    exp_q.delete();
    read                    = 1'b0;
    data_send_master_enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst                     = 1'b1;
    read                    = 1'b1;
    data_send_master_enable = 1'b1;
    data_send_master        = 8'hA5;
    slave_address           = 7'h2C;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("[TB] reset checks");
    checkOutput("reset_scl", scl, 1);
    checkOutput("reset_sda", sda, 1);
    checkOutput("reset_rx", data_receive_master, 8'h00);
    checkOutput("reset_strobe", data_receive_master_enable, 0);
    checkOutput("reset_error", error_master, 0);
    read                    = 1'b0;
    data_send_master_enable = 1'b0;
    rst                     = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("idle_scl_after_reset", scl, 1);
    checkOutput("idle_sda_after_reset", sda, 1);

    $display("[TB] write 4B/93");
    applyStimulus(7'h4B, 8'h93, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    $display("[TB] read 4B -> AD");
    applyStimulus(7'h4B, 8'hAD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    $display("[TB] address NACK");
    applyStimulus(7'h12, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("error_hold_idle", error_master, 1);
    $display("[TB] data NACK on write");
    applyStimulus(7'h5A, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("[TB] write with commands poked while busy");
    applyStimulus(7'h33, 8'hC5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    $display("[TB] read and write together");
    applyStimulus(7'h7F, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    $display("[TB] read 00 -> 52 with busy pokes");
    applyStimulus(7'h00, 8'h52, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    $display("[TB] read with address NACK");
    applyStimulus(7'h66, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    checkOutput("read_queue_drained", rd_q.size(), 0);
    checkOutput("final_idle_scl", scl, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
